// File: rtl/imm_ext_pipe_pkg.sv
// Shared encodings for the immediate extender pipe.
// Mode and skid-buffer state values used by decoder and buffer.
package imm_ext_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } imm_mode_t;

    // State value doubles as the stored-result count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender.
// Sign, zero, upper and branch-offset forms selected by mode.
module imm_ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic [OUT_W-1:0] ext_out
);

    localparam int EXT_W = OUT_W - IN_W;

    imm_mode_t        mode;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] upper;
    logic [OUT_W-1:0] branch;

    assign mode   = imm_mode_t'(in_mode);
    assign sext   = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    assign zext   = {{EXT_W{1'b0}}, in_imm};
    assign upper  = {in_imm, {EXT_W{1'b0}}};
    assign branch = {sext[OUT_W-3:0], 2'b00};

    always_comb begin
        ext_out = '0;
        unique case (mode)
            MODE_SIGN:   ext_out = sext;
            MODE_ZERO:   ext_out = zext;
            MODE_UPPER:  ext_out = upper;
            MODE_BRANCH: ext_out = branch;
            default:     ext_out = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender followed by a 2-entry skid buffer.
// in_ready is registered so it never sees out_ready combinationally.
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       occupancy
);

    buf_state_t       state;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] oreg;
    logic [OUT_W-1:0] sreg;
    logic             in_ready_q;
    logic             in_fire;
    logic             out_fire;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .in_imm  (in_imm),
        .in_mode (in_mode),
        .ext_out (ext)
    );

    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = out_valid && out_ready;
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign out_data  = oreg;
    assign occupancy = state;

    // OREG is cleared on the way to EMPTY so out_data reads 0 there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_EMPTY;
            oreg       <= '0;
            sreg       <= '0;
            in_ready_q <= 1'b0;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_fire) begin
                        oreg  <= ext;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    unique case ({in_fire, out_fire})
                        2'b10: begin
                            sreg       <= ext;
                            state      <= ST_FULL;
                            in_ready_q <= 1'b0;
                        end
                        2'b01: begin
                            oreg  <= '0;
                            state <= ST_EMPTY;
                        end
                        2'b11: begin
                            oreg <= ext;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_FULL: begin
                    if (out_fire) begin
                        oreg       <= sreg;
                        sreg       <= '0;
                        state      <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_EMPTY;
                    oreg       <= '0;
                    sreg       <= '0;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
